spi_arbiter: RTL

Round-robin arbiter that shares one `spi_controller` between `NUM_REQ` independent clients. It grants the controller to one client at a time, issues that client's start pulse, muxes its byte and chip-select hold onto the controller, and routes `done` and received data back. It sits between the SPI peripheral drivers (flash, ADC, configuration) and the single `spi_controller` instance driving the physical bus.

---
 rtl/spi_arb_pkg.sv | 14 +
 rtl/rr_select.sv | 37 +++
 rtl/spi_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and limits for the SPI client arbiter.
package spi_arb_pkg;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request searching upward from
// last_owner+1 with wrap. Shared with the other bus arbiters.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       start;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign req_dbl = {req, req};
  assign start   = (IDX_W+1)'(last_owner) + (IDX_W+1)'(1);
  assign rot     = NUM_REQ'(req_dbl >> start);

  always_comb begin
    int pos;
    pos    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        pos   = int'(start) + k;
      end
    end
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    winner = IDX_W'(pos);
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_controller between NUM_REQ clients.
// Define SPI_ARB_LOCK_EN to lock the grant across multi-byte CS-held bursts.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_hold_cs,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [7:0]              rx_data,
  output logic                    ctl_start,
  output logic [7:0]              ctl_data_to_send,
  output logic                    ctl_hold_cs,
  input  logic                    ctl_busy,
  input  logic                    ctl_done,
  input  logic [7:0]              ctl_data_received
);

  arb_state_t          state_reg;
  logic [IDX_W-1:0]    owner_reg;
  logic [IDX_W-1:0]    last_owner_reg;
  logic [NUM_REQ-1:0]  gnt_reg;
  logic [NUM_REQ-1:0]  req_done_reg;
  logic [7:0]          rx_reg;
  logic                start_reg;
  logic [IDX_W-1:0]    sel_winner;
  logic                sel_valid;
  logic                lock_burst;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_owner_reg),
    .winner     (sel_winner),
    .valid      (sel_valid)
  );

`ifdef SPI_ARB_LOCK_EN
  assign lock_burst  = req_hold_cs[owner_reg];
  assign ctl_hold_cs = req_hold_cs[owner_reg] & (|gnt_reg);
`else
  logic unused_hold_cs;
  assign unused_hold_cs = ^req_hold_cs;
  assign lock_burst     = 1'b0;
  assign ctl_hold_cs    = 1'b0;
`endif

  assign ctl_data_to_send = (|gnt_reg) ? req_data[owner_reg] : 8'h00;
  assign gnt              = gnt_reg;
  assign req_done         = req_done_reg;
  assign rx_data          = rx_reg;
  assign ctl_start        = start_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
      gnt_reg        <= '0;
      req_done_reg   <= '0;
      rx_reg         <= 8'h00;
      start_reg      <= 1'b0;
    end else begin
      req_done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_valid && !ctl_busy) begin
            owner_reg <= sel_winner;
            gnt_reg   <= NUM_REQ'(1) << sel_winner;
            start_reg <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          start_reg <= 1'b0;
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // gnt_reg is the owner's one-hot, so it doubles as the done pulse.
          if (ctl_done) begin
            req_done_reg <= gnt_reg;
            rx_reg       <= ctl_data_received;
            if (!lock_burst) state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ctl_busy) begin
            gnt_reg        <= '0;
            last_owner_reg <= owner_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
